// File: rtl/fifo_port_arbiter.sv
// FIFO built on one shared single-port SRAM. Push and pop contend for the single
// SRAM port; a registered read pipeline presents popped words with a ready handshake.
module fifo_port_arbiter #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 7
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             push_req_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             push_gnt_o,
   input  logic             pop_req_i,
   output logic             pop_gnt_o,
   output logic             pop_valid_o,
   output logic [WIDTH-1:0] pop_data_o,
   input  logic             pop_ready_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o,
   output logic             overflow_o,
   output logic             sram_cen_o,
   output logic             sram_wen_o,
   output logic [AW-1:0]    sram_addr_o,
   output logic [WIDTH-1:0] sram_wdata_o,
   input  logic [WIDTH-1:0] sram_rdata_i
);

   typedef enum logic [1:0] {StIdle, StRdPend, StOutValid} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             last_gnt_q, last_gnt_d;
   logic [WIDTH-1:0] pop_data_q, pop_data_d;
   logic             push_elig, pop_elig;

   assign count_o     = count_q;
   assign full_o      = (count_q == (AW+1)'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign pop_valid_o = (state_q == StOutValid);
   assign pop_data_o  = pop_data_q;

   // Grants are gated by reset so the reset cycle itself never touches the SRAM.
   always_comb begin
      push_elig = rst_ni && push_req_i && !full_o && (state_q != StRdPend) && !clr_i;
      pop_elig  = rst_ni && pop_req_i && !empty_o && !clr_i &&
                  ((state_q == StIdle) || ((state_q == StOutValid) && pop_ready_i));
      // last_gnt_q: 0 = push granted last, 1 = pop granted last.
      push_gnt_o = push_elig && (!pop_elig || last_gnt_q);
      pop_gnt_o  = pop_elig && (!push_elig || !last_gnt_q);
      overflow_o = rst_ni && push_req_i && full_o;
   end

   always_comb begin
      sram_cen_o   = 1'b1;
      sram_wen_o   = 1'b1;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      if (push_gnt_o) begin
         sram_cen_o   = 1'b0;
         sram_wen_o   = 1'b0;
         sram_addr_o  = wptr_q;
         sram_wdata_o = push_data_i;
      end else if (pop_gnt_o) begin
         sram_cen_o  = 1'b0;
         sram_addr_o = rptr_q;
      end
   end

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      last_gnt_d = last_gnt_q;
      state_d    = state_q;
      pop_data_d = pop_data_q;

      if (push_gnt_o) begin
         wptr_d     = wptr_q + AW'(1);
         count_d    = count_q + (AW+1)'(1);
         last_gnt_d = 1'b0;
      end else if (pop_gnt_o) begin
         rptr_d     = rptr_q + AW'(1);
         count_d    = count_q - (AW+1)'(1);
         last_gnt_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (pop_gnt_o) state_d = StRdPend;
         end
         StRdPend: begin
            state_d    = StOutValid;
            pop_data_d = sram_rdata_i;
         end
         StOutValid: begin
            if (pop_ready_i) state_d = pop_gnt_o ? StRdPend : StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Clear abandons any read in flight; the last presented word may linger on pop_data_o.
      if (clr_i) begin
         wptr_d     = '0;
         rptr_d     = '0;
         count_d    = '0;
         state_d    = StIdle;
         pop_data_d = pop_data_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         last_gnt_q <= 1'b1;
         pop_data_q <= '0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         last_gnt_q <= last_gnt_d;
         pop_data_q <= pop_data_d;
      end
   end

endmodule

// File: doc/fifo_port_arbiter.md
FIFO_PORT_ARBITER -- requirements
Module: fifo_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 128, words in the shared single-port SRAM FIFO.
REQ-002 SHALL have parameter WIDTH, default 8, data bits per word.
REQ-003 SHALL have parameter AW, default 7, SRAM address width (DEPTH = 2**AW).
REQ-004 SHALL have clk_i  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have clr_i  input  1  synchronous FIFO clear.
REQ-007 SHALL have push_req_i  input  1  writer requests a push.
REQ-008 SHALL have push_data_i  input  WIDTH  push data.
REQ-009 SHALL have push_gnt_o  output  1  push accepted this cycle.
REQ-010 SHALL have pop_req_i  input  1  reader requests a pop.
REQ-011 SHALL have pop_gnt_o  output  1  pop accepted this cycle.
REQ-012 SHALL have pop_valid_o  output  1  pop_data_o holds a popped word.
REQ-013 SHALL have pop_data_o  output  WIDTH  popped word.
REQ-014 SHALL have pop_ready_i  input  1  reader consumes pop_data_o.
REQ-015 SHALL have full_o, empty_o  output  1 each  occupancy flags.
REQ-016 SHALL have count_o  output  AW+1  words stored.
REQ-017 SHALL have overflow_o  output  1  one-cycle pulse: push_req_i while full.
REQ-018 SHALL have sram_cen_o, sram_wen_o  output  1 each  SRAM chip/write enable, active-low.
REQ-019 SHALL have sram_addr_o  output  AW  SRAM address.
REQ-020 SHALL have sram_wdata_o  output  WIDTH  SRAM write data.
REQ-021 SHALL have sram_rdata_i  input  WIDTH  SRAM Q, valid the cycle after a read access.

Function
REQ-022 SHALL issue at most one SRAM access per cycle; push_gnt_o and pop_gnt_o never both 1.
REQ-023 SHALL use read FSM states IDLE, RD_PEND, OUT_VALID.
REQ-024 SHALL treat push as eligible when push_req_i and !full_o and state != RD_PEND and !clr_i.
REQ-025 SHALL treat pop as eligible when pop_req_i and !empty_o and !clr_i, and (state==IDLE, or state==OUT_VALID with pop_ready_i=1).
REQ-026 SHALL grant combinationally in the request cycle; a sole eligible requester is always granted.
REQ-027 SHALL, when both are eligible, grant the side opposite to last_gnt; last_gnt updates on every grant (0=push, 1=pop).
REQ-028 SHALL, on push grant: sram_cen_o=0, sram_wen_o=0, sram_addr_o=wptr, sram_wdata_o=push_data_i; wptr increments mod DEPTH.
REQ-029 SHALL, on pop grant: sram_cen_o=0, sram_wen_o=1, sram_addr_o=rptr; rptr increments mod DEPTH; next state RD_PEND.
REQ-030 SHALL, with no grant, drive sram_cen_o=1, sram_wen_o=1, sram_addr_o=0 and sram_wdata_o=0.
REQ-031 SHALL, in RD_PEND, load sram_rdata_i into pop_data_o at the clock edge; next state OUT_VALID.
REQ-032 SHALL assert pop_valid_o only in OUT_VALID, with pop_data_o held stable until pop_ready_i=1.
REQ-033 SHALL, in OUT_VALID with pop_ready_i=1, go to RD_PEND on a new pop grant, else to IDLE.
REQ-034 SHALL give pop latency 2: grant at N, pop_valid_o=1 from N+2.
REQ-035 SHALL update count_o at grant: +1 on push, -1 on pop; it never wraps.
REQ-036 SHALL derive full_o = (count_o==DEPTH) and empty_o = (count_o==0) from registered count.
REQ-037 SHALL let a word pushed at cycle N be popped from cycle N+1.
REQ-038 SHALL pulse overflow_o for one cycle in each cycle with push_req_i=1 and full_o=1, with no grant.
REQ-039 SHALL give pop_req_i while empty no grant and no error.
REQ-040 SHALL, on clr_i=1, grant nothing and next cycle have wptr=rptr=0, count_o=0, state IDLE, pop_valid_o=0; pop_data_o may keep its value.

Reset
REQ-041 SHALL, with rst_ni=0 at a rising edge, set wptr=rptr=0, count_o=0, state IDLE, last_gnt=1, pop_valid_o=0, pop_data_o=0 and overflow_o=0; outputs give empty_o=1, full_o=0, no grants, sram_cen_o=1.
REQ-042 SHALL give reset priority over clr_i and all requests, including mid-read (RD_PEND or OUT_VALID), and drop any in-flight word.

Verification
REQ-043 SHALL be verified: after reset, push 0xA5 then pop with pop_ready_i=1 -> push_gnt_o at N, pop_gnt_o at N+1, pop_valid_o=1 at N+3 with pop_data_o=0xA5, count_o back to 0.
REQ-044 SHALL be verified: push_req_i and pop_req_i held high, count_o=5, pop_ready_i=1 -> grants alternate starting with push (last_gnt=1 after reset), no double grant, and no push grant while in RD_PEND.
REQ-045 SHALL be verified: 128 consecutive pushes -> full_o=1, count_o=128; 129th push gets no grant and overflow_o pulses; wptr wraps to 0.
REQ-046 SHALL be verified: pop_ready_i=0 for 10 cycles with pop_valid_o=1 -> pop_data_o stable, no pop grant, pushes still granted.
REQ-047 SHALL be verified: clr_i during OUT_VALID with count_o=3 -> next cycle pop_valid_o=0, count_o=0, empty_o=1, and pop_req_i is not granted.
REQ-048 SHALL be verified: rst_ni=0 in the RD_PEND cycle -> next cycle pop_valid_o=0, empty_o=1, sram_cen_o=1.
